// File: rtl/sqrt_result_capture.sv
// Clocked capture stage behind the square-root unit's asynchronous output stage: four-phase eval/ack handshake into a FWFT FIFO.
// Optional watchdog on stalled handshakes is enabled with `define SQRT_RESULT_CAPTURE_TIMEOUT_EN.
module sqrt_result_capture #(
    parameter int DW          = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
`ifdef SQRT_RESULT_CAPTURE_TIMEOUT_EN
    ,
    parameter int TO_W        = 8
`endif
) (
    input  logic          ck,
    input  logic          arst,
    input  logic          enable_i,
    input  logic          ack_i,
    input  logic [DW-1:0] data_i,
    output logic          eval_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          busy_o,
`ifdef SQRT_RESULT_CAPTURE_TIMEOUT_EN
    output logic          timeout_o,
`endif
    output logic [15:0]   cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] RTZ  = 2'd3;

    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [1:0]             state, state_nxt;
    logic [DW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   full, push, pop, timeout_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ck or posedge arst) begin
        if (arst) ack_sync <= '0;
        else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    assign full = (count == FULL_CNT);
    assign push = (state == CAPT);
    assign pop  = out_valid_o && out_ready_i;

    // NOTE: state_nxt is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (enable_i && !full) state_nxt = EVAL;
            EVAL: if (ack_s)             state_nxt = CAPT;
            CAPT:                        state_nxt = RTZ;
            RTZ:  if (!ack_s)            state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
        if (timeout_hit) state_nxt = IDLE;
    end

    // eval_o is a dedicated flop so the C-element gate never sees decode glitches.
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            eval_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            eval_o <= (state_nxt == EVAL);
        end
    end

    // Data is sampled while eval_o is still high and rails are valid; the slot was reserved in IDLE.
    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge ck) begin
        if (state == EVAL && ack_s) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt_o  <= cnt_o + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign out_valid_o = (count != '0);
    assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
    assign busy_o      = (state != IDLE);

`ifdef SQRT_RESULT_CAPTURE_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);
    logic [TO_W-1:0] to_cnt;

    // Fires on the edge the counter would reach all-ones.
    assign timeout_hit = (state == EVAL || state == RTZ) && (to_cnt == TO_LAST);

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (state_nxt != state && (state_nxt == EVAL || state_nxt == RTZ)) to_cnt <= '0;
            else if (state == EVAL || state == RTZ)                         to_cnt <= to_cnt + 1'b1;
            if (timeout_hit) timeout_o <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
